datamemory_pipe: RTL and testbench
==================================

DATAMEMORY_PIPE -- requirements
Module: datamemory_pipe

Interface
REQ-001 Parameter DM_ADDRESS, default 11: byte-address width; capacity is 2**DM_ADDRESS bytes, organised as 2**(DM_ADDRESS-2) 32-bit words.
REQ-002 Parameter DATA_W, default 32: data width; only 32 is legal, and any other value shall fail elaboration.
REQ-003 clk  in  1  single clock; all state changes on posedge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request this cycle.
REQ-007 MemRead  in  1  request is a load.
REQ-008 MemWrite  in  1  request is a store.
REQ-009 a  in  DM_ADDRESS  byte address.
REQ-010 wd  in  DATA_W  store data, LSB-justified.
REQ-011 Funct3  in  3  RV32I width/sign code.
REQ-012 rsp_valid  out  1  one-cycle response pulse.
REQ-013 rd  out  DATA_W  load result; valid only while rsp_valid=1.
REQ-014 err  out  1  request rejected; qualified by rsp_valid.

Function
REQ-015 A request shall be accepted on a posedge where req_valid=1 and req_ready=1; all request inputs are sampled only at that edge.
REQ-016 Supported Funct3 codes: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-017 A request shall be rejected when any of the following holds: MemRead and MemWrite are both 1; both are 0; the Funct3 code is unsupported for the operation.
REQ-018 On rejection: no memory write; rsp_valid=1 and err=1 on the next cycle; rd=0.
REQ-019 Bytes are little-endian; byte k of an access is stored at address a+k.
REQ-020 Loads: LB and LH sign-extend from bit 7 and bit 15; LBU and LHU zero-extend.
REQ-021 An access whose bytes lie within one word shall be serviced in one cycle:
- Stores commit at the accept edge.
- Loads return rd with rsp_valid=1 on the cycle after acceptance.
REQ-022 An access whose bytes straddle a word boundary is a crossing access: LH/SH at offset 3, or LW/SW at offset 1, 2 or 3.
REQ-023 FSM states: IDLE and SPLIT.
- In IDLE, req_ready=1.
- A crossing accept moves IDLE to SPLIT.
- In SPLIT, req_ready=0; SPLIT returns to IDLE after one cycle.
REQ-024 Throughput: one non-crossing request per cycle, back-to-back; the response of request N and the acceptance of request N+1 may share a cycle.
REQ-025 Crossing access:
- First word is accessed at the accept edge.
- Second word (word index +1) is accessed at the SPLIT edge.
- rsp_valid is asserted on the cycle after SPLIT, giving 2-cycle latency.
REQ-026 The second-word index shall wrap modulo 2**(DM_ADDRESS-2), so the top word wraps to word 0.
REQ-027 A load accepted on the cycle after a store to the same bytes shall return the new data.
REQ-028 Stores assert rsp_valid with err=0 and rd=0; rsp_valid shall never be asserted without a preceding accept.
REQ-029 Memory contents are not initialised and not reset.

Reset
REQ-030 While rst_n=0 at a posedge:
- State shall go to IDLE.
- rsp_valid, err and rd shall be set to 0, and req_ready shall be 0.
- No request is accepted.
REQ-031 req_ready shall be 1 from the first cycle after rst_n returns to 1.
REQ-032 Reset during SPLIT shall abandon the second beat:
- The first-word bytes of a store remain committed.
- The second-word bytes are unwritten.
- No response is issued.

Configuration
REQ-033 Macro DM_MISALIGN_EN.
- Defined: crossing accesses are handled per REQ-023 to REQ-026.
- Undefined: a crossing access is rejected per REQ-018 in one cycle, the SPLIT state does not exist, and req_ready is constant 1 outside reset.

Verification
REQ-034 SW wd=0x8899AABB to a=0x010, then LW a=0x010 -> rd=0x8899AABB, err=0, and the load response arrives one cycle after its accept.
REQ-035 After REQ-034: LB a=0x011 -> rd=0xFFFFFFAA; LBU a=0x011 -> rd=0x000000AA; LH a=0x012 -> rd=0xFFFF8899; LHU a=0x012 -> rd=0x00008899.
REQ-036 With DM_MISALIGN_EN defined: SW 0x11223344 to a=0x7FE (DM_ADDRESS=11), then LW a=0x7FE -> rd=0x11223344, and bytes 0x000 and 0x001 hold 0x22 and 0x11.
- req_ready=0 for one cycle; response two cycles after accept.
REQ-037 With DM_MISALIGN_EN undefined: SH a=0x013 -> rsp_valid=1, err=1 on the next cycle, and memory at 0x013 and 0x014 is unchanged.
REQ-038 Illegal requests: MemRead=MemWrite=1 -> err=1, no write; Funct3=011 load -> err=1, rd=0.
REQ-039 Reset in SPLIT: rst_n=0 during an SW crossing at a=0x021 -> no rsp_valid, bytes 0x021 to 0x023 written, byte 0x024 unchanged, req_ready=1 one cycle after release.

Source files
------------

// File: rtl/datamemory_pipe.sv
`default_nettype none
// ============================================================================
// Module      : datamemory_pipe
// Description : Byte-addressable RV32I data memory with a valid/ready request
//               port and a one-cycle response pulse. Requests whose bytes stay
//               within one 32-bit word are serviced in a single cycle. Define
//               DM_MISALIGN_EN to service word-crossing accesses in two beats
//               through a SPLIT state. Without it, such accesses are rejected.
// Revision    : 1.0 - initial release
// ============================================================================
module datamemory_pipe #(
  parameter int DM_ADDRESS = 11,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DM_ADDRESS-1:0] a,
  input  logic [DATA_W-1:0]     wd,
  input  logic [2:0]            Funct3,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rd,
  output logic                  err
);

  localparam int c_WA     = DM_ADDRESS - 2;
  localparam int c_NWORDS = 2 ** c_WA;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("datamemory_pipe: DATA_W must be 32");
  end

  logic [31:0]     r_mem [0:c_NWORDS-1];
  logic            r_rdy_en;
  logic [c_WA-1:0] w_idx, w_rd_idx, w_wr_idx;
  logic [1:0]      w_off;
  logic            w_ld_ok, w_st_ok, w_legal, w_cross, w_reject, w_accept;
  logic            w_in_split;
  logic [3:0]      w_mask4, w_wr_en;
  logic [7:0]      w_be8;
  logic [63:0]     w_wd64;
  logic [31:0]     w_wr_data, w_rd_word, w_split_rd;

  // Align the access window, then sign- or zero-extend according to Funct3.
  function automatic logic [31:0] f_extract(input logic [63:0] i_win,
                                            input logic [1:0]  i_off,
                                            input logic [2:0]  i_f3);
    logic [31:0] v_sh;
    v_sh = 32'(i_win >> {i_off, 3'b000});
    case (i_f3)
      3'b000:  f_extract = {{24{v_sh[7]}}, v_sh[7:0]};
      3'b001:  f_extract = {{16{v_sh[15]}}, v_sh[15:0]};
      3'b100:  f_extract = {24'h0, v_sh[7:0]};
      3'b101:  f_extract = {16'h0, v_sh[15:0]};
      default: f_extract = v_sh;
    endcase
  endfunction

  assign w_idx    = a[DM_ADDRESS-1:2];
  assign w_off    = a[1:0];
  assign w_accept = rst_n && req_valid && req_ready;

  // Decode legality, crossing detection and store byte lanes.
  always_comb begin
    w_ld_ok = 1'b0;
    case (Funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_ld_ok = 1'b1;
      default:                                w_ld_ok = 1'b0;
    endcase
    w_st_ok = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
    w_legal = (MemRead && !MemWrite && w_ld_ok) || (MemWrite && !MemRead && w_st_ok);
    // Funct3[1:0] encodes access size for both loads and stores.
    w_cross = ((Funct3[1:0] == 2'b01) && (w_off == 2'd3)) ||
              ((Funct3[1:0] == 2'b10) && (w_off != 2'd0));
    case (Funct3[1:0])
      2'b00:   w_mask4 = 4'b0001;
      2'b01:   w_mask4 = 4'b0011;
      default: w_mask4 = 4'b1111;
    endcase
    // Lanes 3:0 land in the addressed word, lanes 7:4 in the next word.
    w_be8  = {4'b0000, w_mask4} << w_off;
    w_wd64 = 64'(wd) << {w_off, 3'b000};
  end

`ifdef DM_MISALIGN_EN
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SPLIT = 1'b1} state_t;
  state_t          r_state, w_state_nxt;
  logic [c_WA-1:0] r_idx1;
  logic [3:0]      r_hi_be;
  logic [31:0]     r_hi_data, r_lo_word;
  logic [1:0]      r_off;
  logic [2:0]      r_f3;
  logic            r_is_store;
  logic            w_go_split;

  assign w_in_split = rst_n && (r_state == S_SPLIT);
  assign req_ready  = r_rdy_en && (r_state == S_IDLE);
  assign w_reject   = !w_legal;
  assign w_go_split = w_accept && w_legal && w_cross;
  assign w_rd_idx   = w_in_split ? r_idx1 : w_idx;
  assign w_split_rd = r_is_store ? 32'h0 : f_extract({w_rd_word, r_lo_word}, r_off, r_f3);

  // State register; reset abandons any pending second beat.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: a crossing accept spends exactly one cycle in SPLIT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go_split) w_state_nxt = S_SPLIT;
      S_SPLIT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Hold the second-beat context (wrapping word index, high lanes, first word).
  always_ff @(posedge clk) begin
    if (w_go_split) begin
      r_idx1     <= w_idx + c_WA'(1);
      r_hi_be    <= w_be8[7:4];
      r_hi_data  <= w_wd64[63:32];
      r_lo_word  <= w_rd_word;
      r_off      <= w_off;
      r_f3       <= Funct3;
      r_is_store <= MemWrite;
    end
  end
`else
  logic w_unused;
  assign w_in_split = 1'b0;
  assign req_ready  = r_rdy_en;
  assign w_reject   = !w_legal || w_cross;
  assign w_rd_idx   = w_idx;
  assign w_split_rd = 32'h0;
  assign w_unused   = ^{w_be8[7:4], w_wd64[63:32]};
`endif

  assign w_rd_word = r_mem[w_rd_idx];

  // Single write port: second-beat lanes during SPLIT, otherwise accepted store lanes.
  always_comb begin
    w_wr_en   = 4'b0000;
    w_wr_idx  = w_idx;
    w_wr_data = w_wd64[31:0];
`ifdef DM_MISALIGN_EN
    if (w_in_split) begin
      w_wr_idx  = r_idx1;
      w_wr_data = r_hi_data;
      if (r_is_store) w_wr_en = r_hi_be;
    end else
`endif
    if (w_accept && !w_reject && MemWrite) begin
      w_wr_en = w_be8[3:0];
    end
  end

  // Byte-lane writes into the word array; contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr_en[i]) r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
    end
  end

  // Response pulse, error flag and load data; also gates req_ready out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdy_en  <= 1'b0;
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      rd        <= '0;
    end else begin
      r_rdy_en  <= 1'b1;
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      rd        <= '0;
      if (w_in_split) begin
        rsp_valid <= 1'b1;
        rd        <= w_split_rd;
      end else if (w_accept) begin
        if (w_reject) begin
          rsp_valid <= 1'b1;
          err       <= 1'b1;
        end else if (!w_cross) begin
          rsp_valid <= 1'b1;
          if (MemRead) rd <= f_extract({32'h0, w_rd_word}, w_off, Funct3);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_datamemory_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_datamemory_pipe
// Description : Directed self-checking bench for datamemory_pipe. Covers the
//               DM_MISALIGN_EN build when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datamemory_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [10:0] a = '0;
  logic [31:0] wd = '0;
  logic [2:0]  Funct3 = '0;
  logic        rsp_valid;
  logic [31:0] rd;
  logic        err;

  int n_cmp = 0;
  int n_mis = 0;

  datamemory_pipe #(.DM_ADDRESS(11), .DATA_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3),
    .rsp_valid(rsp_valid), .rd(rd), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request; returns 1 time unit after its accept edge.
  task automatic issue(input logic i_rd, input logic i_wr, input logic [10:0] i_a,
                       input logic [31:0] i_wd, input logic [2:0] i_f3);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; MemRead = i_rd; MemWrite = i_wr; a = i_a; wd = i_wd; Funct3 = i_f3;
    @(posedge clk);
    #1;
    req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; wd = '0;
  endtask

  task automatic store_chk(input string tag, input logic [10:0] i_a,
                           input logic [31:0] i_wd, input logic [2:0] i_f3);
    issue(1'b0, 1'b1, i_a, i_wd, i_f3);
    check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_rd"}, rd, 32'h0);
  endtask

  task automatic load_chk(input string tag, input logic [10:0] i_a,
                          input logic [2:0] i_f3, input logic [31:0] exp);
    issue(1'b1, 1'b0, i_a, 32'h0, i_f3);
    check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_rd"}, rd, exp);
  endtask

  task automatic reject_chk(input string tag, input logic i_rd, input logic i_wr,
                            input logic [10:0] i_a, input logic [31:0] i_wd, input logic [2:0] i_f3);
    issue(i_rd, i_wr, i_a, i_wd, i_f3);
    check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_rd"}, rd, 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_vld", 32'(rsp_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rd", rd, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rel_ready_pre", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rel_ready", 32'(req_ready), 32'd1);

    // Store then back-to-back load of the same word
    store_chk("sw010", 11'h010, 32'h8899AABB, 3'b010);
    load_chk("lw010", 11'h010, 3'b010, 32'h8899AABB);
    @(posedge clk);
    #1;
    check("lw010_pulse_end", 32'(rsp_valid), 32'd0);

    // Sub-word loads with sign/zero extension
    load_chk("lb011", 11'h011, 3'b000, 32'hFFFFFFAA);
    load_chk("lbu011", 11'h011, 3'b100, 32'h000000AA);
    load_chk("lh012", 11'h012, 3'b001, 32'hFFFF8899);
    load_chk("lhu012", 11'h012, 3'b101, 32'h00008899);

    // Illegal requests
    reject_chk("both", 1'b1, 1'b1, 11'h010, 32'h0, 3'b010);
    load_chk("lw010_after_both", 11'h010, 3'b010, 32'h8899AABB);
    reject_chk("ld011code", 1'b1, 1'b0, 11'h010, 32'h0, 3'b011);
    reject_chk("neither", 1'b0, 1'b0, 11'h010, 32'h0, 3'b000);
    reject_chk("st100code", 1'b0, 1'b1, 11'h010, 32'h0, 3'b100);
    load_chk("lw010_after_rej", 11'h010, 3'b010, 32'h8899AABB);

    // Byte and halfword store lanes
    store_chk("sb012", 11'h012, 32'hFFFFFF77, 3'b000);
    store_chk("sh010", 11'h010, 32'hABCD1234, 3'b001);
    load_chk("lw010_lanes", 11'h010, 3'b010, 32'h88771234);
    store_chk("sw014", 11'h014, 32'h01020304, 3'b010);

`ifdef DM_MISALIGN_EN
    // Crossing store/load that wraps from the top word to word 0
    issue(1'b0, 1'b1, 11'h7FE, 32'h11223344, 3'b010);
    check("sw7fe_ready_split", 32'(req_ready), 32'd0);
    check("sw7fe_vld_early", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("sw7fe_vld", 32'(rsp_valid), 32'd1);
    check("sw7fe_err", 32'(err), 32'd0);
    check("sw7fe_ready_back", 32'(req_ready), 32'd1);
    issue(1'b1, 1'b0, 11'h7FE, 32'h0, 3'b010);
    check("lw7fe_vld_early", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lw7fe_vld", 32'(rsp_valid), 32'd1);
    check("lw7fe_rd", rd, 32'h11223344);
    load_chk("lbu000", 11'h000, 3'b100, 32'h00000022);
    load_chk("lbu001", 11'h001, 3'b100, 32'h00000011);

    // Reset during SPLIT abandons the second beat
    store_chk("sw020", 11'h020, 32'h00000000, 3'b010);
    store_chk("sw024", 11'h024, 32'hA5A5A5A5, 3'b010);
    issue(1'b0, 1'b1, 11'h021, 32'hDDCCBBAA, 3'b010);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("splitrst_vld", 32'(rsp_valid), 32'd0);
    check("splitrst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("splitrst_ready_back", 32'(req_ready), 32'd1);
    check("splitrst_vld_back", 32'(rsp_valid), 32'd0);
    load_chk("lw020_after_rst", 11'h020, 3'b010, 32'hCCBBAA00);
    load_chk("lbu024_after_rst", 11'h024, 3'b100, 32'h000000A5);
`else
    // Crossing accesses are rejected in one cycle and leave memory untouched
    reject_chk("sh013", 1'b0, 1'b1, 11'h013, 32'h00005566, 3'b001);
    check("sh013_ready", 32'(req_ready), 32'd1);
    load_chk("lbu013", 11'h013, 3'b100, 32'h00000088);
    load_chk("lbu014", 11'h014, 3'b100, 32'h00000004);
    reject_chk("lw011", 1'b1, 1'b0, 11'h011, 32'h0, 3'b010);
    reject_chk("sw7fe", 1'b0, 1'b1, 11'h7FE, 32'h11223344, 3'b010);
    load_chk("lw014_after", 11'h014, 3'b010, 32'h01020304);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
